// File: rtl/clock_sync_multi.sv
// clock_sync_multi
// Multi-channel synchroniser and edge-timing block for asynchronous 68k-bus
// strobes and clocks entering the SYSCLK domain. Each channel has a
// SYNC_STAGES-deep synchroniser, registered rise/fall pulses and a delay
// line with two shared, runtime-selectable rise taps. Channel 0 also drives
// a period meter that reports its rise-to-rise interval in SYSCLK cycles.
// All state advances on the falling edge of SYSCLK.
module clock_sync_multi #(
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DELAY_DEPTH = 32,
    parameter int TAP_W       = 5,
    parameter int PERIOD_W    = 8
) (
    input  logic                SYSCLK,
    input  logic                nRESET,
    input  logic [CHANNELS-1:0] SIG_IN,
    input  logic [TAP_W-1:0]    TAP_A,
    input  logic [TAP_W-1:0]    TAP_B,
    output logic [CHANNELS-1:0] SYNC_OUT,
    output logic [CHANNELS-1:0] RISE,
    output logic [CHANNELS-1:0] FALL,
    output logic [CHANNELS-1:0] DLY_RISE_A,
    output logic [CHANNELS-1:0] DLY_RISE_B,
    output logic [PERIOD_W-1:0] PERIOD,
    output logic                PERIOD_VALID
);

    // Period meter states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Highest usable tap: a tap compares dl[t] with dl[t+1].
    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(DELAY_DEPTH - 2);
    localparam logic [TAP_W-1:0] TAP_ONE = TAP_W'(1);

    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    // Synchroniser chain, one vector per stage, all channels side by side.
    (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;

    logic [CHANNELS-1:0] dl_q [DELAY_DEPTH];

    logic [TAP_W-1:0]    tap_a_eff;
    logic [TAP_W-1:0]    tap_a_nxt;
    logic [TAP_W-1:0]    tap_b_eff;
    logic [TAP_W-1:0]    tap_b_nxt;
    logic [CHANNELS-1:0] dly_a_d;
    logic [CHANNELS-1:0] dly_b_d;

    logic [1:0]          state_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W:0]   cnt_inc;
    logic [PERIOD_W-1:0] period_sat;
    logic                r0;

    // Shift the asynchronous inputs through the synchroniser stages.
    // NOTE: every clocked block uses non-blocking assignments so each stage
    // samples the value its neighbour held before this edge, not after.
    always_ff @(negedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= SIG_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign SYNC_OUT = sync_q[SYNC_STAGES-1];
    assign rise_d   = SYNC_OUT & ~prev_q;
    assign fall_d   = ~SYNC_OUT & prev_q;

    // Edge history and registered single-cycle rise/fall pulses.
    always_ff @(negedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            prev_q <= '0;
            RISE   <= '0;
            FALL   <= '0;
        end else begin
            prev_q <= SYNC_OUT;
            RISE   <= rise_d;
            FALL   <= fall_d;
        end
    end

    // Delay line fed by the synchronised level.
    // NOTE: this is a flop shift register rather than a RAM, and it must be
    // cleared on reset so an edge in flight cannot emerge after release.
    always_ff @(negedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int i = 0; i < DELAY_DEPTH; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= SYNC_OUT;
            for (int i = 1; i < DELAY_DEPTH; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    // Clamp the tap selects and form the per-channel tap rise terms.
    // NOTE: every signal gets a value on every path through this block, so
    // no latch is inferred.
    always_comb begin
        tap_a_eff = (TAP_A > TAP_MAX) ? TAP_MAX : TAP_A;
        tap_b_eff = (TAP_B > TAP_MAX) ? TAP_MAX : TAP_B;
        tap_a_nxt = tap_a_eff + TAP_ONE;
        tap_b_nxt = tap_b_eff + TAP_ONE;
        dly_a_d   = dl_q[tap_a_eff] & ~dl_q[tap_a_nxt];
        dly_b_d   = dl_q[tap_b_eff] & ~dl_q[tap_b_nxt];
    end

    // Register the tap pulses.
    always_ff @(negedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            DLY_RISE_A <= '0;
            DLY_RISE_B <= '0;
        end else begin
            DLY_RISE_A <= dly_a_d;
            DLY_RISE_B <= dly_b_d;
        end
    end

    // Interval candidate, one bit wider than the counter so a full count
    // saturates instead of wrapping to zero.
    assign r0         = rise_d[0];
    assign cnt_inc    = {1'b0, cnt_q} + {{PERIOD_W{1'b0}}, 1'b1};
    assign period_sat = cnt_inc[PERIOD_W] ? CNT_MAX : cnt_inc[PERIOD_W-1:0];

    // Channel 0 period meter: arm on a rise, measure to the next rise,
    // drop back to idle when the counter tops out with no rise.
    always_ff @(negedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            PERIOD       <= '0;
            PERIOD_VALID <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (r0) begin
                        cnt_q   <= '0;
                        state_q <= ST_ARMED;
                    end
                end
                ST_ARMED, ST_LOCKED: begin
                    if (r0) begin
                        // A rise on the timeout cycle still counts as a
                        // measurement; it just saturates.
                        PERIOD       <= period_sat;
                        cnt_q        <= '0;
                        PERIOD_VALID <= 1'b1;
                        state_q      <= ST_LOCKED;
                    end else if (cnt_q == CNT_MAX) begin
                        PERIOD_VALID <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_inc[PERIOD_W-1:0];
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_sync_multi.sv
// Testbench for clock_sync_multi. A reference model built from sample
// history (what the input was k edges ago) predicts every output on every
// cycle; directed tables and sequences pin down the edge-exact timing of
// pulses, tap clamping, period locking, timeout, saturation and reset.
module tb_clock_sync_multi;

    localparam int CH    = 2;
    localparam int S     = 2;
    localparam int DEPTH = 32;
    localparam int TW    = 5;
    localparam int PW    = 8;
    localparam int TMO   = 1 << PW;
    localparam int PMAX  = TMO - 1;
    localparam int MAXE  = 20000;

    logic          SYSCLK;
    logic          nRESET;
    logic [CH-1:0] SIG_IN;
    logic [TW-1:0] TAP_A;
    logic [TW-1:0] TAP_B;
    logic [CH-1:0] SYNC_OUT;
    logic [CH-1:0] RISE;
    logic [CH-1:0] FALL;
    logic [CH-1:0] DLY_RISE_A;
    logic [CH-1:0] DLY_RISE_B;
    logic [PW-1:0] PERIOD;
    logic          PERIOD_VALID;

    clock_sync_multi #(
        .CHANNELS   (CH),
        .SYNC_STAGES(S),
        .DELAY_DEPTH(DEPTH),
        .TAP_W      (TW),
        .PERIOD_W   (PW)
    ) dut (
        .SYSCLK      (SYSCLK),
        .nRESET      (nRESET),
        .SIG_IN      (SIG_IN),
        .TAP_A       (TAP_A),
        .TAP_B       (TAP_B),
        .SYNC_OUT    (SYNC_OUT),
        .RISE        (RISE),
        .FALL        (FALL),
        .DLY_RISE_A  (DLY_RISE_A),
        .DLY_RISE_B  (DLY_RISE_B),
        .PERIOD      (PERIOD),
        .PERIOD_VALID(PERIOD_VALID)
    );

    initial begin
        SYSCLK = 1'b1;
        forever #5 SYSCLK = ~SYSCLK;
    end

    typedef struct {
        int ch;
        int ta;
        int tb;
        int rise_e;
        int a_e;
        int b_e;
        int fall_e;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: input samples per falling edge, plus the
    // period meter expressed as "time since last channel-0 rise".
    logic [CH-1:0] hs [MAXE];
    int            n         = 0;
    int            rst_mark  = 0;
    int            last_rise = 0;
    bit            have_last = 1'b0;
    bit            m_valid   = 1'b0;
    int            m_period  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, n);
        end
    endtask

    // Input level of channel ch as sampled at edge k; anything at or before
    // the last reset edge reads as 0.
    function automatic logic hv(input int ch, input int k);
        if (k < 1 || k <= rst_mark) return 1'b0;
        return hs[k][ch];
    endfunction

    function automatic int clamp_tap(input int t);
        return (t > DEPTH - 2) ? DEPTH - 2 : t;
    endfunction

    // Rise seen at delay position t, as visible after edge n.
    function automatic logic tap_rise(input int ch, input int t);
        return hv(ch, n - 1 - S - t) & ~hv(ch, n - 2 - S - t);
    endfunction

    // One SYSCLK cycle: model the falling edge, then compare on the rising edge.
    task automatic tick();
        logic [CH-1:0] e_sync, e_rise, e_fall, e_a, e_b;
        logic          r0;
        int            ta, tb;
        @(negedge SYSCLK);
        n++;
        if (n >= MAXE) begin
            $display("FAIL edge_budget: got %0d edges, expected fewer than %0d", n, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        hs[n] = SIG_IN;
        if (!nRESET) begin
            rst_mark  = n;
            have_last = 1'b0;
            m_valid   = 1'b0;
            m_period  = 0;
        end else begin
            r0 = hv(0, n - S) & ~hv(0, n - S - 1);
            if (r0) begin
                if (have_last && (n - last_rise) <= TMO) begin
                    m_period = ((n - last_rise) > PMAX) ? PMAX : (n - last_rise);
                    m_valid  = 1'b1;
                end
                last_rise = n;
                have_last = 1'b1;
            end else if (have_last && (n - last_rise) == TMO) begin
                m_valid   = 1'b0;
                have_last = 1'b0;
            end
        end
        @(posedge SYSCLK);
        ta = clamp_tap(int'(TAP_A));
        tb = clamp_tap(int'(TAP_B));
        for (int c = 0; c < CH; c++) begin
            e_sync[c] = hv(c, n - S + 1);
            e_rise[c] = hv(c, n - S) & ~hv(c, n - S - 1);
            e_fall[c] = ~hv(c, n - S) & hv(c, n - S - 1);
            e_a[c]    = tap_rise(c, ta);
            e_b[c]    = tap_rise(c, tb);
        end
        check("model_sync_out", SYNC_OUT, e_sync);
        check("model_rise", RISE, e_rise);
        check("model_fall", FALL, e_fall);
        check("model_dly_rise_a", DLY_RISE_A, e_a);
        check("model_dly_rise_b", DLY_RISE_B, e_b);
        check("model_period", PERIOD, m_period);
        check("model_period_valid", PERIOD_VALID, m_valid);
    endtask

    task automatic idle(input int k);
        SIG_IN = '0;
        repeat (k) tick();
    endtask

    initial begin
        vec_t vecs [4];
        int   rise_first, rise_cnt, fall_first, fall_cnt;
        int   a_first, a_cnt, b_first, b_cnt;
        int   rises, last_rise_e, drop_e, vcount;
        int   hold [CH];
        int   other_cnt;

        nRESET = 1'b0;
        SIG_IN = '0;
        TAP_A  = '0;
        TAP_B  = 5'd1;

        // Reset: everything is 0, even with the inputs driven high.
        repeat (3) tick();
        SIG_IN = 2'b11;
        repeat (3) tick();
        check("reset_all_outputs_zero",
              {SYNC_OUT, RISE, FALL, DLY_RISE_A, DLY_RISE_B, PERIOD, PERIOD_VALID}, 0);
        SIG_IN = '0;
        tick();
        nRESET = 1'b1;
        idle(10);

        // Single-rise timing table: edges counted from the input change.
        vecs[0] = '{1,  0,  1, 3,  4,  5, 3};
        vecs[1] = '{0, 18, 19, 3, 22, 23, 3};
        vecs[2] = '{0, 31,  5, 3, 34,  9, 3};
        vecs[3] = '{1, 30, 29, 3, 34, 33, 3};
        for (int v = 0; v < 4; v++) begin
            TAP_A = TW'(vecs[v].ta);
            TAP_B = TW'(vecs[v].tb);
            idle(5);
            rise_first = -1; rise_cnt = 0; fall_cnt = 0;
            a_first = -1; a_cnt = 0; b_first = -1; b_cnt = 0;
            SIG_IN[vecs[v].ch] = 1'b1;
            for (int e = 1; e <= 40; e++) begin
                tick();
                if (RISE[vecs[v].ch]) begin
                    if (rise_cnt == 0) rise_first = e;
                    rise_cnt++;
                end
                if (FALL[vecs[v].ch]) fall_cnt++;
                if (DLY_RISE_A[vecs[v].ch]) begin
                    if (a_cnt == 0) a_first = e;
                    a_cnt++;
                end
                if (DLY_RISE_B[vecs[v].ch]) begin
                    if (b_cnt == 0) b_first = e;
                    b_cnt++;
                end
            end
            check($sformatf("vec%0d_rise_edge", v), rise_first, vecs[v].rise_e);
            check($sformatf("vec%0d_rise_count", v), rise_cnt, 1);
            check($sformatf("vec%0d_fall_count_on_rise", v), fall_cnt, 0);
            check($sformatf("vec%0d_tap_a_edge", v), a_first, vecs[v].a_e);
            check($sformatf("vec%0d_tap_a_count", v), a_cnt, 1);
            check($sformatf("vec%0d_tap_b_edge", v), b_first, vecs[v].b_e);
            check($sformatf("vec%0d_tap_b_count", v), b_cnt, 1);
            fall_first = -1; fall_cnt = 0;
            SIG_IN[vecs[v].ch] = 1'b0;
            for (int e = 1; e <= 6; e++) begin
                tick();
                if (FALL[vecs[v].ch]) begin
                    if (fall_cnt == 0) fall_first = e;
                    fall_cnt++;
                end
            end
            check($sformatf("vec%0d_fall_edge", v), fall_first, vecs[v].fall_e);
            check($sformatf("vec%0d_fall_count", v), fall_cnt, 1);
            idle(40);
        end

        // Period meter: clear earlier measurements, then a 10-cycle square wave.
        nRESET = 1'b0;
        repeat (2) tick();
        nRESET = 1'b1;
        idle(5);
        rises = 0;
        last_rise_e = 0;
        for (int i = 0; i < 60; i++) begin
            SIG_IN[0] = ((i % 10) < 5);
            tick();
            if (RISE[0]) begin
                rises++;
                last_rise_e = n;
                if (rises == 1) begin
                    check("p10_first_rise_not_valid", PERIOD_VALID, 0);
                end else begin
                    check("p10_period", PERIOD, 10);
                    check("p10_valid", PERIOD_VALID, 1);
                end
            end
        end
        check("p10_rise_count", rises, 6);

        // Clock stops after lock: valid drops once the count tops out.
        SIG_IN[0] = 1'b0;
        drop_e = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (drop_e < 0 && !PERIOD_VALID) drop_e = n;
        end
        check("p10_timeout_delay", drop_e - last_rise_e, TMO);
        check("p10_period_held", PERIOD, 10);

        // 300-cycle period: too slow to ever lock.
        rises = 0;
        vcount = 0;
        for (int i = 0; i < 900; i++) begin
            SIG_IN[0] = ((i % 300) < 150);
            tick();
            if (PERIOD_VALID) vcount++;
            if (RISE[0]) rises++;
        end
        check("p300_never_valid", vcount, 0);
        check("p300_rise_count", rises, 3);
        idle(60);

        // 256-cycle period: the rise lands on the timeout cycle and wins.
        rises = 0;
        for (int i = 0; i < 600; i++) begin
            SIG_IN[0] = ((i % 256) < 128);
            tick();
            if (RISE[0]) begin
                rises++;
                if (rises >= 2) begin
                    check("p256_period_saturated", PERIOD, PMAX);
                    check("p256_valid", PERIOD_VALID, 1);
                end else begin
                    check("p256_first_rise_not_valid", PERIOD_VALID, 0);
                end
            end
        end
        check("p256_rise_count", rises, 3);
        idle(300);

        // Reset while a tap-B rise is in flight, input held high.
        TAP_A = 5'd3;
        TAP_B = 5'd19;
        idle(5);
        SIG_IN[0] = 1'b1;
        repeat (10) tick();
        nRESET = 1'b0;
        #1;
        check("midreset_async_clear",
              {SYNC_OUT, RISE, FALL, DLY_RISE_A, DLY_RISE_B, PERIOD, PERIOD_VALID}, 0);
        repeat (3) tick();
        nRESET = 1'b1;
        rise_first = -1; rise_cnt = 0; b_first = -1; b_cnt = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (RISE[0]) begin
                if (rise_cnt == 0) rise_first = e;
                rise_cnt++;
            end
            if (DLY_RISE_B[0]) begin
                if (b_cnt == 0) b_first = e;
                b_cnt++;
            end
        end
        check("midreset_high_rise_edge", rise_first, 3);
        check("midreset_high_rise_count", rise_cnt, 1);
        check("midreset_high_tap_b_edge", b_first, 23);
        check("midreset_high_tap_b_count", b_cnt, 1);
        idle(40);

        // Reset while in flight, input dropped during reset: nothing emerges.
        SIG_IN[0] = 1'b1;
        repeat (10) tick();
        nRESET = 1'b0;
        repeat (2) tick();
        SIG_IN[0] = 1'b0;
        tick();
        nRESET = 1'b1;
        rise_cnt = 0; b_cnt = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (RISE[0]) rise_cnt++;
            if (DLY_RISE_B[0]) b_cnt++;
        end
        check("midreset_low_rise_count", rise_cnt, 0);
        check("midreset_low_tap_b_count", b_cnt, 0);

        // Opposite edges on both channels in the same cycle.
        SIG_IN = 2'b10;
        repeat (40) tick();
        SIG_IN = 2'b01;
        rise_first = -1; fall_first = -1; other_cnt = 0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (RISE[0] && rise_first < 0) rise_first = e;
            if (FALL[1] && fall_first < 0) fall_first = e;
            if (RISE[1] || FALL[0]) other_cnt++;
        end
        check("multi_rise0_edge", rise_first, 3);
        check("multi_fall1_edge", fall_first, 3);
        check("multi_no_cross_effect", other_cnt, 0);
        idle(300);

        // Randomised traffic on both channels, new taps between bursts.
        for (int blk = 0; blk < 4; blk++) begin
            idle(45);
            TAP_A = TW'($urandom_range(0, 31));
            TAP_B = TW'($urandom_range(0, 31));
            hold[0] = $urandom_range(1, 160);
            hold[1] = $urandom_range(1, 12);
            for (int i = 0; i < 600; i++) begin
                for (int c = 0; c < CH; c++) begin
                    if (hold[c] == 0) begin
                        SIG_IN[c] = ~SIG_IN[c];
                        hold[c] = (c == 0) ? $urandom_range(1, 160) : $urandom_range(1, 12);
                    end else begin
                        hold[c]--;
                    end
                end
                tick();
            end
        end
        idle(45);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clock_sync_multi.md
# clock_sync_multi

Multi-channel synchroniser and edge-timing block for asynchronous 68k-bus strobes and clocks (MC clock, DTACK, VPA and similar) entering the SYSCLK domain. Each channel gets a configurable-depth synchroniser, single-cycle rise/fall pulses, and a delay line with two runtime-selectable rise taps. Channel 0 also has a period meter that measures its rise-to-rise interval in SYSCLK cycles. It sits between the bus pins and the bus state machines, and replaces per-signal fixed-delay synchronisers.

## Interface
Parameters:
- CHANNELS, 2: number of independent input channels; channel 0 is the period-metered one.
- SYNC_STAGES, 2: synchroniser flops per channel, at least 2, all async_reg.
- DELAY_DEPTH, 32: delay-line length per channel, at least 4.
- TAP_W, 5: tap select width, equal to clog2(DELAY_DEPTH).
- PERIOD_W, 8: period counter and output width.

Ports:
- SYSCLK, in, 1: system clock; all state updates on its falling edge.
- nRESET, in, 1: asynchronous, active-low reset.
- SIG_IN, in, CHANNELS: asynchronous inputs.
- TAP_A, in, TAP_W: delayed-rise tap A select, shared by all channels.
- TAP_B, in, TAP_W: delayed-rise tap B select, shared by all channels.
- SYNC_OUT, out, CHANNELS: synchronised level, equal to the last sync stage.
- RISE, out, CHANNELS: one-cycle pulse on a synchronised rising edge.
- FALL, out, CHANNELS: one-cycle pulse on a synchronised falling edge.
- DLY_RISE_A, out, CHANNELS: one-cycle pulse on a rise seen at tap A.
- DLY_RISE_B, out, CHANNELS: one-cycle pulse on a rise seen at tap B.
- PERIOD, out, PERIOD_W: last measured channel-0 rise-to-rise period, in SYSCLK cycles.
- PERIOD_VALID, out, 1: PERIOD holds a measurement from a live clock.

## Operation
- Reset (nRESET=0, asynchronous) clears all sync stages, the edge-history flops, the delay lines, the counter, RISE, FALL, DLY_RISE_A/B, SYNC_OUT, PERIOD and PERIOD_VALID to 0. The period FSM goes to IDLE.
- Synchroniser: stage 0 samples SIG_IN; each later stage copies the one before it. SYNC_OUT is stage SYNC_STAGES-1. The prev flop holds SYNC_OUT delayed by one cycle.
- Edge pulses (registered): RISE is set by SYNC_OUT & ~prev. FALL is set by ~SYNC_OUT & prev.
- Delay line: dl[0] takes SYNC_OUT; dl[i] takes dl[i-1], for i from 1 to DELAY_DEPTH-1.
- Tap pulse for tap t: DLY_RISE is set by dl[t] & ~dl[t+1].
  - A tap value above DELAY_DEPTH-2 is clamped to DELAY_DEPTH-2.
  - Taps are read combinationally every cycle. Changing a tap while a rise is in flight may drop or duplicate that one pulse. Software changes taps only while the inputs are idle.
- Period FSM on channel 0. Let r0 be the internal rise-detect term, the value being loaded into RISE[0] at this edge.
  - IDLE: on r0, cnt goes to 0 and the FSM moves to ARMED.
  - ARMED: cnt increments each cycle. On r0, PERIOD takes cnt+1, cnt goes to 0, PERIOD_VALID goes to 1, and the FSM moves to LOCKED.
  - LOCKED: same update as ARMED on each r0, and the FSM stays in LOCKED.
  - Counter width: cnt+1 is computed at PERIOD_W+1 bits. If it exceeds 2^PERIOD_W-1, PERIOD saturates to 2^PERIOD_W-1.
  - Timeout: in ARMED or LOCKED, if cnt equals 2^PERIOD_W-1 and r0=0, then PERIOD_VALID goes to 0, the FSM moves to IDLE, and PERIOD keeps its last value.
  - Simultaneous: if r0 and the timeout condition hit on the same edge, r0 wins, PERIOD saturates, and PERIOD_VALID stays 1.
- All channels are independent. Different channels may pulse on the same cycle.

## Timing
- Edge k is the k-th SYSCLK falling edge after SIG_IN changes.
- Stage 0 holds the new value after edge 1. SYNC_OUT holds it after edge SYNC_STAGES.
- RISE and FALL are high from edge SYNC_STAGES+1 to edge SYNC_STAGES+2: exactly one cycle.
- DLY_RISE at tap t is high from edge SYNC_STAGES+2+t for one cycle. Tap 0 therefore fires one cycle after RISE.
- Tap pulses are spaced by tap difference. TAP_B = TAP_A + 1 gives a latch pulse followed by an after-latch pulse on the next cycle.
- PERIOD and PERIOD_VALID update on the same edge that sets RISE[0].
- Input pulses shorter than one SYSCLK cycle may be missed. This is not an error.
- Reset release with SIG_IN already high: the chains restart from 0, so RISE fires at edge SYNC_STAGES+1 after release, and tap pulses follow the normal schedule.

## Test plan
- Reset and single rise: reset, then SIG_IN[1] 0 to 1 with SYNC_STAGES=2.
  - RISE[1] high for exactly one cycle, from edge 3 to edge 4.
  - FALL stays 0; all outputs were 0 during reset.
- Delay taps: TAP_A=18, TAP_B=19, one rise on channel 0.
  - DLY_RISE_A pulses once at edge 22, DLY_RISE_B once at edge 23, each for one cycle.
  - TAP_A=31 behaves as tap 30: pulse at edge 34.
- Period meter: channel 0 square wave of period 10 cycles.
  - PERIOD_VALID stays 0 after the first rise.
  - After the second rise, PERIOD=10 and PERIOD_VALID=1; this holds on every subsequent rise.
- Timeout and saturation with PERIOD_W=8.
  - Channel 0 stops after lock: PERIOD_VALID drops when cnt reaches 255, and PERIOD holds 10.
  - Period of 300 cycles: PERIOD never locks; the FSM cycles between ARMED and IDLE.
- Mid-operation reset: assert nRESET while a tap-B rise is in flight.
  - No DLY_RISE_B pulse appears after release.
  - With SIG_IN held high, a new RISE occurs at edge 3 after release.
- Multi-channel independence: opposite edges on channels 0 and 1 on the same cycle.
  - RISE[0] and FALL[1] fire on the same cycle; no cross-channel effects.
